// File: rtl/gshare_pkg.sv
// rtl/gshare_pkg.sv - shared sizes and counter encodings for the gshare predictor
package gshare_pkg;

  localparam int HIST_W      = 7;
  localparam int PHT_ENTRIES = 2 ** HIST_W;
  localparam int CTR_W       = 2;

  localparam logic [CTR_W-1:0] SNT         = 2'd0;
  localparam logic [CTR_W-1:0] WNT         = 2'd1;
  localparam logic [CTR_W-1:0] WT          = 2'd2;
  localparam logic [CTR_W-1:0] ST          = 2'd3;
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = WNT;

endpackage

// File: rtl/gshare_if.sv
// rtl/gshare_if.sv - predict and train signal bundle for the gshare predictor
interface gshare_if;
  import gshare_pkg::*;

  logic              predict_valid;
  logic [HIST_W-1:0] predict_pc;
  logic              predict_taken;
  logic [HIST_W-1:0] predict_history;

  logic              train_valid;
  logic              train_taken;
  logic              train_mispredicted;
  logic [HIST_W-1:0] train_history;
  logic [HIST_W-1:0] train_pc;

  // Front end / bench side: issues predictions and training updates
  modport master (
    output predict_valid, predict_pc,
    input  predict_taken, predict_history,
    output train_valid, train_taken, train_mispredicted, train_history, train_pc
  );

  // Predictor side
  modport slave (
    input  predict_valid, predict_pc,
    output predict_taken, predict_history,
    input  train_valid, train_taken, train_mispredicted, train_history, train_pc
  );

endinterface

// File: rtl/gshare_sat_counter2.sv
// rtl/gshare_sat_counter2.sv - next value of a 2-bit saturating counter
module sat_counter2
  import gshare_pkg::*;
(
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);

  // Count toward strongly-taken on taken, toward strongly-not-taken otherwise
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_top.sv
// rtl/gshare_top.sv - gshare branch predictor: global history XOR pc into a 2-bit counter table
module gshare_top
  import gshare_pkg::*;
(
  input  logic     clk,
  input  logic     areset_n,
  gshare_if.slave  bp
);

  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;
  logic [CTR_W-1:0]  pht [PHT_ENTRIES];

  logic [HIST_W-1:0] pred_idx;
  logic [HIST_W-1:0] train_idx;
  logic [CTR_W-1:0]  train_ctr_next;
  logic              recover;

  assign pred_idx  = bp.predict_pc ^ ghr_q;
  assign train_idx = bp.train_pc ^ bp.train_history;
  assign recover   = bp.train_valid & bp.train_mispredicted;

  // Prediction reads the counter before any same-cycle training write lands
  assign bp.predict_taken   = pht[pred_idx][1];
  assign bp.predict_history = ghr_q;

  sat_counter2 u_train_ctr (
    .ctr_i   (pht[train_idx]),
    .taken_i (bp.train_taken),
    .ctr_o   (train_ctr_next)
  );

  // History next state: mispredict rollback wins over the speculative shift
  always_comb begin
    ghr_d = ghr_q;
    if (recover) begin
      ghr_d = {bp.train_history[HIST_W-2:0], bp.train_taken};
    end else if (bp.predict_valid) begin
      ghr_d = {ghr_q[HIST_W-2:0], bp.predict_taken};
    end
  end

  // Global history register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Pattern history table: one trained entry per cycle
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht[i] <= CTR_WEAK_NT;
      end
    end else if (bp.train_valid) begin
      pht[train_idx] <= train_ctr_next;
    end
  end

endmodule

// File: tb/tb_gshare_top.sv
// tb/tb_gshare_top.sv - self-checking bench for gshare_top
module tb_gshare_top;
  import gshare_pkg::*;

  logic clk = 1'b0;
  logic areset_n = 1'b0;

  gshare_if bp_if ();

  gshare_top dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bp       (bp_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Golden model state
  logic [6:0] m_ghr;
  logic [1:0] m_pht [128];

  typedef struct {
    logic [6:0] exp_hist;
    logic       tv;
    logic [6:0] tidx;
    logic [1:0] exp_ctr;
  } sb_t;
  sb_t sb_q[$];

  logic       last_taken;
  logic [6:0] last_hist;

  typedef struct {
    logic       pv;
    logic [6:0] ppc;
    logic       tv;
    logic       tt;
    logic       tm;
    logic [6:0] th;
    logic [6:0] tpc;
    logic       exp_taken;
    logic [6:0] exp_hist;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ghr = '0;
    for (int i = 0; i < 128; i++) m_pht[i] = 2'b01;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset_n = 1'b0;
    bp_if.predict_valid = 0; bp_if.train_valid = 0; bp_if.train_mispredicted = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  // Called at a negedge: drive one cycle, check prediction, then check state after the edge
  task automatic step(input logic pv, input logic [6:0] ppc, input logic tv,
                      input logic tt, input logic tm, input logic [6:0] th,
                      input logic [6:0] tpc);
    logic       e_taken;
    logic [6:0] tidx;
    sb_t        e;
    sb_t        got;
    bp_if.predict_valid      = pv;
    bp_if.predict_pc         = ppc;
    bp_if.train_valid        = tv;
    bp_if.train_taken        = tt;
    bp_if.train_mispredicted = tm;
    bp_if.train_history      = th;
    bp_if.train_pc           = tpc;
    #1;
    e_taken = m_pht[ppc ^ m_ghr][1];
    last_taken = bp_if.predict_taken;
    chk("predict_taken", int'(bp_if.predict_taken), int'(e_taken));
    tidx = tpc ^ th;
    if (tv) begin
      if (tt && m_pht[tidx] != 2'd3) m_pht[tidx] = m_pht[tidx] + 2'd1;
      else if (!tt && m_pht[tidx] != 2'd0) m_pht[tidx] = m_pht[tidx] - 2'd1;
    end
    if (tv && tm) m_ghr = {th[5:0], tt};
    else if (pv) m_ghr = {m_ghr[5:0], e_taken};
    e.exp_hist = m_ghr; e.tv = tv; e.tidx = tidx; e.exp_ctr = m_pht[tidx];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    last_hist = bp_if.predict_history;
    chk("predict_history", int'(bp_if.predict_history), int'(got.exp_hist));
    if (got.tv) chk("pht_update", int'(dut.pht[got.tidx]), int'(got.exp_ctr));
    @(negedge clk);
    bp_if.predict_valid = 0; bp_if.train_valid = 0; bp_if.train_mispredicted = 0;
  endtask

  logic [1:0] sat_exp [8];

  initial begin
    bp_if.predict_valid = 0; bp_if.predict_pc = '0;
    bp_if.train_valid = 0; bp_if.train_taken = 0; bp_if.train_mispredicted = 0;
    bp_if.train_history = '0; bp_if.train_pc = '0;

    // Reset state
    do_reset();
    chk("reset_history", int'(bp_if.predict_history), 0);
    chk("reset_pht3", int'(dut.pht[3]), 1);
    begin
      int bad = 0;
      for (int p = 0; p < 128; p++) begin
        bp_if.predict_pc = 7'(p);
        #0.1;
        if (bp_if.predict_taken !== 1'b0) bad++;
      end
      chk("reset_taken_all_pc", bad, 0);
    end

    // Table-driven vectors from reset, expected outputs derived by hand
    //          pv ppc    tv tt tm th     tpc    taken hist
    vecs[0] = '{1, 7'h03, 0, 0, 0, 7'h00, 7'h00, 0, 7'h00};
    vecs[1] = '{0, 7'h00, 1, 1, 0, 7'h00, 7'h03, 0, 7'h00};
    vecs[2] = '{1, 7'h03, 0, 0, 0, 7'h00, 7'h00, 1, 7'h01};
    vecs[3] = '{0, 7'h03, 1, 1, 1, 7'h0F, 7'h0F, 0, 7'h1F};
    vecs[4] = '{1, 7'h1F, 0, 0, 0, 7'h00, 7'h00, 1, 7'h3F};
    vecs[5] = '{0, 7'h00, 0, 0, 0, 7'h00, 7'h00, 0, 7'h3F};
    vecs[6] = '{0, 7'h3F, 0, 1, 1, 7'h55, 7'h00, 1, 7'h3F};
    vecs[7] = '{1, 7'h00, 1, 0, 1, 7'h0F, 7'h00, 0, 7'h1E};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].pv, vecs[i].ppc, vecs[i].tv, vecs[i].tt, vecs[i].tm,
           vecs[i].th, vecs[i].tpc);
      chk($sformatf("vec%0d_taken", i), int'(last_taken), int'(vecs[i].exp_taken));
      chk($sformatf("vec%0d_hist", i), int'(last_hist), int'(vecs[i].exp_hist));
      if (i == 1) chk("vec1_pht3", int'(dut.pht[3]), 2);
    end
    chk("vec7_pht15", int'(dut.pht[15]), 0);

    // Saturation on index 5
    do_reset();
    sat_exp = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 8; i++) begin
      step(0, 7'h00, 1, (i < 4), 0, 7'h00, 7'h05);
      chk($sformatf("sat_step%0d", i), int'(dut.pht[5]), int'(sat_exp[i]));
    end

    // Same-entry collision on index 9 with GHR still zero
    step(1, 7'h09, 1, 1, 0, 7'h00, 7'h09);
    chk("collide_taken", int'(last_taken), 0);
    chk("collide_pht9", int'(dut.pht[9]), 2);

    // Recovery priority: load GHR=1010101, then collide mispredict with predict
    step(0, 7'h00, 1, 1, 1, 7'h2A, 7'h00);
    chk("load_hist", int'(last_hist), 7'h55);
    step(1, 7'h00, 1, 1, 1, 7'h0F, 7'h00);
    chk("recover_hist", int'(last_hist), 7'h1F);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2;
    areset_n = 1'b0;
    #1;
    chk("async_reset_hist", int'(bp_if.predict_history), 0);
    chk("async_reset_pht9", int'(dut.pht[9]), 1);
    model_reset();
    @(negedge clk);
    areset_n = 1'b1;

    // Random predict-then-train against the model
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom), 7'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 7'($urandom), 7'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_top.md
GSHARE_TOP -- requirements
Module: gshare_top

Interface
REQ-001 The block SHALL have the ports: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have the ports: areset_n  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have the ports: predict_valid  input  1  a prediction is consumed this cycle.
REQ-004 The block SHALL have the ports: predict_pc  input  7  branch PC to predict.
REQ-005 The block SHALL have the ports: predict_taken  output  1  combinational prediction.
REQ-006 The block SHALL have the ports: predict_history  output  7  current global history register (GHR).
REQ-007 The block SHALL have the ports: train_valid  input  1  resolved branch update this cycle.
REQ-008 The block SHALL have the ports: train_taken  input  1  actual branch outcome.
REQ-009 The block SHALL have the ports: train_mispredicted  input  1  the branch was mispredicted, so the GHR is restored.
REQ-010 The block SHALL have the ports: train_history  input  7  GHR value captured at prediction time.
REQ-011 The block SHALL have the ports: train_pc  input  7  PC of the resolved branch.

Function
REQ-012 The block SHALL have these state elements: a 7-bit GHR and a 128-entry x 2-bit pattern history table (PHT) of saturating counters, held in flops as an array named pht that is indexable hierarchically.
REQ-013 The prediction index SHALL be predict_pc XOR GHR, 7 bits, with no hashing beyond XOR.
REQ-014 predict_taken SHALL equal pht[index] bit 1. It is purely combinational from predict_pc and the current GHR and PHT, with zero latency, and is driven regardless of predict_valid.
REQ-015 predict_history SHALL equal the GHR directly, with no combinational dependence on inputs.
REQ-016 On a rising edge with predict_valid=1, the GHR SHALL become {GHR[5:0], predict_taken}, with the oldest bit dropped.
REQ-017 The training index SHALL be train_pc XOR train_history.
REQ-018 On a rising edge with train_valid=1, pht[train index] SHALL increment if train_taken=1, saturating at 3, and decrement if train_taken=0, saturating at 0.
REQ-019 On a rising edge with train_valid=1 and train_mispredicted=1, the GHR SHALL become {train_history[5:0], train_taken}.
REQ-020 If a mispredict recovery and predict_valid occur in the same cycle, the recovery SHALL take priority and the predict shift is discarded.
REQ-021 If train_valid=1 and train_mispredicted=0, the GHR SHALL be affected only by predict_valid.
REQ-022 If a prediction and a training update hit the same PHT entry in one cycle, predict_taken SHALL reflect the pre-update counter, and the update SHALL apply at the edge.
REQ-023 train_mispredicted SHALL be ignored when train_valid=0.
REQ-024 When neither predict_valid nor train_valid is asserted, all state SHALL hold.
REQ-025 The block SHALL use no handshake or backpressure: one prediction and one training update can be accepted every cycle.

Reset
REQ-026 While areset_n=0, the GHR SHALL be 0, so predict_history=0.
REQ-027 While areset_n=0, all 128 PHT entries SHALL be 2'b01 (weakly not-taken), so predict_taken=0 for every index.
REQ-028 Reset SHALL act asynchronously on assertion and override any in-flight predict or train operation.
REQ-029 After deassertion, normal operation SHALL begin at the first rising edge.

Structure
REQ-030 A shared package SHALL hold HIST_W=7, PHT_ENTRIES=128 (2**HIST_W), CTR_W=2, the counter reset constant CTR_WEAK_NT=2'b01, and the counter encodings SNT=0, WNT=1, WT=2, ST=3.
REQ-031 One sub-module, sat_counter2, SHALL compute the next value of a 2-bit saturating counter from the current value and the outcome. It is used on the training path.
REQ-032 The PHT write and the GHR update SHALL each be a single always block with an asynchronous reset.

Verification
REQ-033 Reset: assert areset_n=0, then release -> predict_history=7'b0000000, pht[3]=2'b01, predict_taken=0 for any PC.
REQ-034 Predict/shift: GHR=0, predict_pc=3, predict_valid=1 for one cycle -> predict_taken=0, and next GHR=7'b0000000. Then train pc=3, history=0, taken=1, no mispredict -> pht[3]=2'b10 and GHR unchanged.
REQ-035 Saturation: train index 5 with taken=1 four times -> counter 01->10->11->11. Train index 5 with taken=0 four times -> 11->10->01->00->00.
REQ-036 Recovery priority: GHR=7'b1010101, with predict_valid=1 and train_valid=1, train_mispredicted=1, train_history=7'b0001111, train_taken=1 in the same cycle -> GHR=7'b0011111.
REQ-037 Same-entry collision: pht[9]=2'b01, predict index 9 and train index 9 with taken=1 in the same cycle -> predict_taken=0 during that cycle, and pht[9]=2'b10 afterwards.
REQ-038 Random: 500 iterations of random predict then train, with a golden model checking predict_taken, the GHR shift, the PHT update and mispredict rollback every cycle.
